negedge_event_capture: RTL
==========================

NEGEDGE_EVENT_CAPTURE -- requirements
Module: negedge_event_capture

Interface
REQ-001 The block SHALL have parameter TS_W, default 8: timestamp width.
REQ-002 The block SHALL have parameter DEPTH, default 4: event FIFO depth, a power of two.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port a_in, input, 1 bit: external line A, asynchronous, idle high.
REQ-006 The block SHALL have port b_in, input, 1 bit: external line B, asynchronous, idle high.
REQ-007 The block SHALL have port en, input, 1 bit: capture enable.
REQ-008 The block SHALL have port clr, input, 1 bit: single-cycle pulse that clears error state.
REQ-009 The block SHALL have port ev_valid, output, 1 bit: an event record is available.
REQ-010 The block SHALL have port ev_ready, input, 1 bit: the downstream consumer accepts the record.
REQ-011 The block SHALL have port ev_code, output, 2 bits: 01 = A fell, 10 = B fell, 11 = both fell in the same cycle.
REQ-012 The block SHALL have port ev_ts, output, TS_W bits: timestamp of the event.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag for a lost event.
REQ-014 The block SHALL have port drop_cnt, output, 8 bits: count of lost events.

Function
REQ-015 a_in and b_in SHALL each pass through a 2-flop synchronizer; synchronizer flops reset to 1.
REQ-016 A falling edge SHALL be detected in cycle k when the synchronized value was 1 in cycle k-1 and is 0 in cycle k; rising edges SHALL be ignored.
REQ-017 A free-running TS_W-bit counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-018 The event timestamp SHALL be the counter value in detection cycle k.
REQ-019 Simultaneous A and B detections SHALL produce one record with code 11, not two.
REQ-020 The FSM SHALL have three states: IDLE (no capture), RUN (capture), HALT (no capture after an overflow).
REQ-021 FSM transitions: IDLE->RUN when en=1; RUN->IDLE when en=0; RUN->HALT on the first dropped event; HALT->RUN on clr if en=1; HALT->IDLE on clr if en=0.
REQ-022 In RUN, a detected event SHALL be written to the FIFO in cycle k.
REQ-023 The FIFO SHALL be DEPTH entries of {code, ts}, show-ahead; ev_valid/ev_code/ev_ts SHALL be driven from registered FIFO state.
REQ-024 Latency: with an empty FIFO, ev_valid SHALL rise in cycle k+1; the total from a pin edge is 3-4 cycles.
REQ-025 Handshake: a pop SHALL occur only when ev_valid and ev_ready are both 1 at a clk edge.
REQ-026 ev_code/ev_ts SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-027 When full, a push coinciding with a pop SHALL succeed with no drop.
REQ-028 A push when full without a pop SHALL be a drop: overflow set to 1, drop_cnt incremented.
REQ-029 Events detected in HALT SHALL count as drops; events in IDLE SHALL be ignored and not counted.
REQ-030 drop_cnt SHALL saturate at 255.
REQ-031 clr SHALL zero overflow and drop_cnt; clr SHALL take priority over a drop in the same cycle.
REQ-032 The FIFO SHALL continue to drain in every state.
REQ-033 FIFO read and write pointers SHALL be log2(DEPTH)+1 bits and wrap naturally; full/empty SHALL be decoded from the extra pointer bit.

Reset
REQ-034 On rst=0, asynchronously: state=IDLE, FIFO empty, ev_valid=0, ev_code=0, ev_ts=0, overflow=0, drop_cnt=0, timestamp counter=0, synchronizers=1.
REQ-035 Reset asserted mid-transfer SHALL discard all queued records; no spurious edge SHALL be detected after release.

Structure
REQ-036 Event code constants (A=01, B=10, BOTH=11) and FSM state encodings SHALL live in a shared package/header used by this block and its downstream consumer.
REQ-037 The FIFO SHALL be a sub-module named event_fifo, parameterised by width and DEPTH.

Verification
REQ-038 Scenario 1: en=1, a_in driven 1->0 with the FIFO empty -> ev_valid rises 3-4 cycles later, ev_code=01, ev_ts equals the counter value at detection.
REQ-039 Scenario 2: a_in and b_in fall on the same clk edge -> exactly one record, ev_code=11.
REQ-040 Scenario 3: ev_ready=0 and 5 edges alternating A/B -> 4 records queued, overflow=1, drop_cnt=1, state HALT; further edges raise drop_cnt to 2 and 3.
REQ-041 Scenario 4: FIFO full, an edge coincides with a pop (ev_ready=1) -> no drop and the new record is enqueued; then clr with en=1 -> overflow=0, drop_cnt=0, state RUN.
REQ-042 Scenario 5: timestamp crossing 255->0 between two events -> ts values are 255 and 0, in order.
REQ-043 Scenario 6: rst asserted with 3 records queued -> ev_valid=0 immediately; after release, no events until a new falling edge.

Source files
------------

// File: rtl/negedge_event_capture_pkg.sv
// Shared definitions for the falling-edge event capture block and its consumers:
// event codes, FSM state encoding and the drop-counter ceiling.
package negedge_event_capture_pkg;

    // Event codes carried in each record: bit 0 = line A fell, bit 1 = line B fell
    localparam logic [1:0] EV_NONE = 2'b00;
    localparam logic [1:0] EV_A    = 2'b01;
    localparam logic [1:0] EV_B    = 2'b10;
    localparam logic [1:0] EV_BOTH = 2'b11;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // not capturing
        ST_RUN  = 2'd1,   // capturing into the FIFO
        ST_HALT = 2'd2    // stopped after a lost event, waiting for clr
    } state_e;

    // Drop counter is 8 bits and saturates here
    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Map the two per-line detections onto a single record code
    function automatic logic [1:0] ev_code_f(input logic fell_a, input logic fell_b);
        logic [1:0] code;
        case ({fell_b, fell_a})
            2'b01:   code = EV_A;
            2'b10:   code = EV_B;
            2'b11:   code = EV_BOTH;
            default: code = EV_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead FIFO for event records. The head entry is always presented on
// rdata_o straight from the storage registers, so the consumer sees a record in
// the cycle after it was written. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate count. DEPTH must be a
// power of two, at least 2.
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the head slot in the same edge, so a push into a full FIFO
    // alongside a pop is accepted (it lands in the slot being vacated).
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update: both wrap naturally through the extra MSB
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Record storage; cleared on reset so the head reads as zero afterwards
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/negedge_event_capture.sv
// Falling-edge event capture: two asynchronous lines are synchronised, their
// falling edges detected and time-stamped with a free-running counter, and the
// resulting records queued in a FIFO for a valid/ready consumer. Events that
// cannot be queued are counted as drops and halt capture until cleared.
module negedge_event_capture
    import negedge_event_capture_pkg::*;
#(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_in,
    input  logic            b_in,
    input  logic            en,
    input  logic            clr,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [1:0]      ev_code,
    output logic [TS_W-1:0] ev_ts,
    output logic            overflow,
    output logic [7:0]      drop_cnt
);

    localparam int REC_W = 2 + TS_W;

    logic [1:0]       line_in;
    logic [1:0]       fell;
    logic [TS_W-1:0]  ts_q;
    state_e           state_q;
    logic             overflow_q;
    logic [7:0]       drop_cnt_q;
    logic             event_hit;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_push;
    logic             drop;
    logic [REC_W-1:0] rec_wdata;
    logic [REC_W-1:0] rec_rdata;

    assign line_in = {b_in, a_in};

    // Per-line two-flop synchroniser plus one history flop. All reset high
    // (the idle level) so releasing reset can never look like a falling edge.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_sync
        logic sync1_q;
        logic sync2_q;
        logic prev_q;

        // Shift the raw line through the synchroniser and keep last cycle's value
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                prev_q  <= 1'b1;
            end else begin
                sync1_q <= line_in[gi];
                sync2_q <= sync1_q;
                prev_q  <= sync2_q;
            end
        end

        // High only on a 1 -> 0 transition of the synchronised line
        assign fell[gi] = prev_q & ~sync2_q;
    end

    // Free-running timestamp, wraps from all-ones to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign event_hit = |fell;
    assign rec_wdata = {ev_code_f(fell[0], fell[1]), ts_q};
    assign fifo_pop  = ev_valid && ev_ready;

    // A record is lost when capturing into a full FIFO with no pop this edge,
    // or whenever an event arrives while halted. Idle events are ignored.
    assign fifo_push = event_hit && (state_q == ST_RUN) && (!fifo_full || fifo_pop);
    assign drop      = event_hit &&
                       (((state_q == ST_RUN) && fifo_full && !fifo_pop) ||
                        (state_q == ST_HALT));

    // Capture FSM: a drop while running halts capture until clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (en) state_q <= ST_RUN;
                ST_RUN: begin
                    if (drop)     state_q <= ST_HALT;
                    else if (!en) state_q <= ST_IDLE;
                end
                ST_HALT: if (clr) state_q <= en ? ST_RUN : ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; clr beats a same-cycle drop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clr) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != DROP_MAX) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n_i (rst),
        .push_i  (fifo_push),
        .wdata_i (rec_wdata),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (rec_rdata)
    );

    assign ev_valid = !fifo_empty;
    assign ev_code  = rec_rdata[REC_W-1:TS_W];
    assign ev_ts    = rec_rdata[TS_W-1:0];
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
